sa_output_deskew: RTL and testbench
===================================

# sa_output_deskew

Realigns the diagonally skewed result wavefront leaving the systolic array back into whole rows. Lane i of a row leaves the array i stall-qualified cycles after lane 0. This block delays each lane so that all lanes of one row land in a single output register. It sits between the array's output edge and the result writeback, and stalls on the same `okay` enable as the array. It also checks that the wavefront stays consistent and frames the result stream.

## Interface
- `LANES`, 4, number of array output lanes (≥2)
- `WIDTH`, 8, data bits per lane
- `CNT_W`, 16, width of the frame row counter

- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `okay`  in  1  global advance enable; 0 = whole block holds
- `in_valid`  in  LANES  per-lane valid; bit i pairs with lane i
- `in_data`  in  LANES*WIDTH  lane i at bits [i*WIDTH +: WIDTH]
- `in_last`  in  1  marks lane 0 of the final row of a frame; qualified by `in_valid[0]`
- `out_valid`  out  1  aligned row present
- `out_data`  out  LANES*WIDTH  aligned row, same lane packing as input
- `out_last`  out  1  row on `out_data` is the final row of the frame
- `done`  out  1  one-cycle pulse after the last-row beat
- `busy`  out  1  frame in flight (FSM in ACTIVE)
- `frame_rows`  out  CNT_W  row count of the most recently completed frame
- `err_skew`  out  1  sticky wavefront-misalignment flag

## Operation
- Lane i delay line: LANES-1-i stages, each carrying data and valid. Lane 0 also carries `in_last`.
- All delay stages and the output register advance only on clocks where `okay`=1. When `okay`=0, every stage and every output holds its value; only `done` behaves differently (see below).
- Alignment point: the delayed lane 0..LANES-2 signals plus the undelayed lane LANES-1 signals.
- At each `okay`=1 edge, the valids at the alignment point are checked:
  - All 1: the output register loads the row; `out_valid`=1; `out_last` = delayed last.
  - All 0: `out_valid`=0; `out_data` is loaded anyway (don't-care).
  - Mixed: `out_valid`=0, `out_last`=0, and `err_skew` is set. The partial row is dropped. `err_skew` clears only on `rst`.
- A beat is transferred on every clock where `out_valid`=1 and `okay`=1. The consumer samples the beat on that clock.
- Row counter:
  - Increments on each transferred beat, wrapping modulo 2^CNT_W.
  - On the beat with `out_last`=1, `frame_rows` takes the counter value + 1 (mod 2^CNT_W) and the counter clears to 0.
- `done` is registered: `done` <= `out_valid` & `out_last` & `okay`. It is independent of `okay` in the following cycle, so it is exactly one cycle wide.
- FSM:
  - IDLE → ACTIVE on an `okay`=1 edge with `in_valid[0]`=1.
  - ACTIVE → IDLE on the edge where `done` is asserted. If a new lane-0 valid is present on that same edge, the FSM goes to ACTIVE instead (new frame wins).
  - `busy`=1 while in ACTIVE.
- `rst`: every delay stage, the output register and counters clear to 0, and the FSM goes to IDLE.
  - Reset values: `out_valid`=0, `out_data`=0, `out_last`=0, `done`=0, `busy`=0, `frame_rows`=0, `err_skew`=0.
  - No stale row or `done` pulse may appear after reset.

## Timing
- Latency in `okay`=1 cycles, counted from presentation to visibility on `out_*`:
  - lane 0: LANES
  - lane i: LANES-i
  - lane LANES-1: 1
- Full throughput: one row per `okay`=1 cycle with no bubbles.
- Stalls add cycles one for one; no data is lost or duplicated.
- `done` appears 1 clock after the last-row beat.
- `frame_rows` is valid from the same clock as `done` and holds until the next frame completes.
- `busy` rises 1 clock after the first lane-0 valid edge and falls with the `done` edge.
- Simultaneous `rst` and any other input: `rst` wins.

## Test plan
All scenarios use LANES=4, WIDTH=8.
- **Reset:** assert `rst` for 2 cycles with random inputs and `okay`=1 → all outputs 0 and `busy`=0 the next cycle.
- **Single row:** lane i valid with data 0x10+i at cycle i (cycles 0–3), `in_last` at cycle 0, `okay`=1 → `out_valid`=1 only in cycle 4 with `out_data`=0x13121110 and `out_last`=1; `done`=1 in cycle 5; `frame_rows`=1.
- **Stream:** 6 back-to-back rows (row r, lane i = 16r+i), `in_last` on row 5 → 6 consecutive beats in cycles 4–9 in order; `out_last` only in cycle 9; `done` in cycle 10; `frame_rows`=6; `busy` high in cycles 1–9.
- **Stall:** same stream with `okay`=0 in cycles 5–6 → outputs frozen during the stall; beats in cycles 4 and 7–11; `done` in cycle 12; no duplicated or missing rows.
- **Skew error:** single row with lane 2 presented at cycle 3 instead of 2 → no `out_valid` for that row, `err_skew`=1 from cycle 4 onward, persisting until `rst`.
- **Mid-frame reset:** `rst` in cycle 3 of a stream → cycle 4 has all outputs 0; a following clean frame produces the correct rows, `frame_rows` and `done`, with no residue from the aborted frame.

Source files
------------

// File: rtl/sa_output_deskew.sv
// rtl/sa_output_deskew.sv - realigns the skewed systolic-array output wavefront into whole rows
module sa_output_deskew #(
    parameter int LANES = 4,
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   okay,
    input  logic [LANES-1:0]       in_valid,
    input  logic [LANES*WIDTH-1:0] in_data,
    input  logic                   in_last,
    output logic                   out_valid,
    output logic [LANES*WIDTH-1:0] out_data,
    output logic                   out_last,
    output logic                   done,
    output logic                   busy,
    output logic [CNT_W-1:0]       frame_rows,
    output logic                   err_skew
);
    localparam logic [0:0]       S_IDLE   = 1'b0;
    localparam logic [0:0]       S_ACTIVE = 1'b1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [LANES-1:0]       w_al_valid;
    logic [LANES*WIDTH-1:0] w_al_data;
    logic                   w_al_last;
    logic                   w_all;
    logic                   w_any;
    logic                   w_beat;
    logic                   w_frame_end;

    logic                   r_out_valid;
    logic [LANES*WIDTH-1:0] r_out_data;
    logic                   r_out_last;
    logic                   r_done;
    logic                   r_err;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       r_frame_rows;
    logic [0:0]             r_state;
    logic [LANES-2:0]       r_last;

    // Lane g waits LANES-1-g stages so it meets the last lane at the alignment point.
    for (genvar g = 0; g < LANES - 1; g++) begin : g_lane
        localparam int D = LANES - 1 - g;
        logic [WIDTH-1:0] r_data [D];
        logic [D-1:0]     r_valid;

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int k = 0; k < D; k++) r_data[k] <= '0;
                r_valid <= '0;
            end else if (okay) begin
                r_data[0]  <= in_data[g*WIDTH +: WIDTH];
                r_valid[0] <= in_valid[g];
                for (int k = 1; k < D; k++) begin
                    r_data[k]  <= r_data[k-1];
                    r_valid[k] <= r_valid[k-1];
                end
            end
        end

        assign w_al_data[g*WIDTH +: WIDTH] = r_data[D-1];
        assign w_al_valid[g]               = r_valid[D-1];
    end

    assign w_al_data[(LANES-1)*WIDTH +: WIDTH] = in_data[(LANES-1)*WIDTH +: WIDTH];
    assign w_al_valid[LANES-1]                 = in_valid[LANES-1];

    // The frame marker rides alongside lane 0, gated by its valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= '0;
        end else if (okay) begin
            r_last[0] <= in_last & in_valid[0];
            for (int k = 1; k < LANES - 1; k++) r_last[k] <= r_last[k-1];
        end
    end

    assign w_al_last   = r_last[LANES-2];
    assign w_all       = &w_al_valid;
    assign w_any       = |w_al_valid;
    assign w_beat      = r_out_valid & okay;
    assign w_frame_end = w_beat & r_out_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_err       <= 1'b0;
        end else if (okay) begin
            r_out_valid <= w_all;
            r_out_data  <= w_al_data;
            r_out_last  <= w_all & w_al_last;
            if (w_any && !w_all) r_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= '0;
            r_frame_rows <= '0;
        end else if (w_beat) begin
            if (r_out_last) begin
                r_frame_rows <= r_cnt + CNT_ONE;
                r_cnt        <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_ONE;
            end
        end
    end

    // done is not gated by okay so it never stretches across a stall.
    always_ff @(posedge clk) begin
        if (rst) r_done <= 1'b0;
        else     r_done <= w_frame_end;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:   if (okay && in_valid[0]) r_state <= S_ACTIVE;
                S_ACTIVE: if (w_frame_end) r_state <= in_valid[0] ? S_ACTIVE : S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_last   = r_out_last;
    assign done       = r_done;
    assign busy       = (r_state == S_ACTIVE);
    assign frame_rows = r_frame_rows;
    assign err_skew   = r_err;
endmodule

// File: tb/tb_sa_output_deskew.sv
// tb/tb_sa_output_deskew.sv - directed bench for sa_output_deskew
module tb_sa_output_deskew;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        okay = 1'b1;
    logic [3:0]  in_valid = '0;
    logic [31:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_last;
    logic        done;
    logic        busy;
    logic [15:0] frame_rows;
    logic        err_skew;

    int checks = 0;
    int errors = 0;

    sa_output_deskew #(.LANES(4), .WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .okay(okay),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .done(done), .busy(busy), .frame_rows(frame_rows), .err_skew(err_skew)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] row_word(input int row, input int base);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[i*8 +: 8] = 8'(16 * (row + base) + i);
        return w;
    endfunction

    // Array-side skew: lane i of row r appears at step r+i (lane 2 delayed by x2 extra).
    task automatic drive(input int s, input int n, input int base, input int x2);
        logic [3:0]  v;
        logic [31:0] d;
        logic        l;
        v = '0; d = '0; l = 1'b0;
        for (int i = 0; i < 4; i++) begin
            int r;
            r = s - i - ((i == 2) ? x2 : 0);
            if (r >= 0 && r < n) begin
                v[i] = 1'b1;
                d[i*8 +: 8] = 8'(16 * (r + base) + i);
                if (i == 0 && r == n - 1) l = 1'b1;
            end
        end
        in_valid = v; in_data = d; in_last = l;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_data"},  out_data, 0);
        chk({tag, "_last"},  out_last, 0);
        chk({tag, "_done"},  done, 0);
        chk({tag, "_busy"},  busy, 0);
        chk({tag, "_rows"},  frame_rows, 0);
        chk({tag, "_err"},   err_skew, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1; okay = 1'b1;
        for (int k = 0; k < 2; k++) begin
            in_valid = 4'($urandom_range(0, 15));
            in_data  = $urandom;
            in_last  = 1'($urandom_range(0, 1));
            tick();
        end
        rst = 1'b0; in_valid = '0; in_data = '0; in_last = 1'b0;
    endtask

    // Outputs at cycle c reflect k okay-edges of progress; done_cyc is hand-derived.
    task automatic run_frame(input int n, input int base, input int st_lo, input int st_hi, input int done_cyc);
        int  k = 0;
        bit  prev_end = 0;
        bit  done_seen = 0;
        int  beats = 0;
        int  done_obs = -1;
        for (int c = 0; c < n + 10; c++) begin
            bit ev, el, ok;
            ev = (k >= 4) && (k < 4 + n);
            el = ev && (k == 3 + n);
            if (prev_end) done_seen = 1;
            chk("valid", out_valid, ev);
            if (ev) chk("data", out_data, row_word(k - 4, base));
            chk("last", out_last, el);
            chk("done", done, prev_end);
            chk("busy", busy, (c >= 1) && !done_seen);
            chk("err", err_skew, 0);
            if (done_seen) chk("frame_rows", frame_rows, n);
            if (done === 1'b1 && done_obs < 0) done_obs = c;
            ok = !(c >= st_lo && c <= st_hi);
            okay = ok;
            if (out_valid === 1'b1 && ok) beats++;
            drive(k, n, base, 0);
            prev_end = ev && el && ok;
            @(posedge clk);
            if (ok) k++;
            #1;
        end
        okay = 1'b1;
        chk("beat_count", beats, n);
        chk("done_cycle", done_obs, done_cyc);
    endtask

    initial begin
        // Reset with random inputs
        do_reset();
        chk_zero("reset");

        do_reset();
        run_frame(1, 1, -1, -2, 5);

        do_reset();
        run_frame(6, 0, -1, -2, 10);

        do_reset();
        run_frame(6, 0, 5, 6, 12);

        // Skew error, no reset in between: frame_rows of the stall frame must survive
        for (int c = 0; c < 10; c++) begin
            chk("skew_valid", out_valid, 0);
            chk("skew_done", done, 0);
            chk("skew_err", err_skew, c >= 4);
            okay = 1'b1;
            drive(c, 1, 1, 1);
            tick();
        end
        chk("skew_rows_hold", frame_rows, 6);

        // Mid-frame reset
        for (int c = 0; c < 3; c++) begin
            okay = 1'b1;
            drive(c, 6, 0, 0);
            tick();
        end
        rst = 1'b1;
        drive(3, 6, 0, 0);
        tick();
        rst = 1'b0; in_valid = '0; in_data = '0; in_last = 1'b0;
        chk_zero("midrst");
        run_frame(3, 8, -1, -2, 7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
